// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM slot arbiter between VGA scanout reads and
// a small CPU write FIFO. One VRAM operation per cycle. A write that has been
// starved for MAX_WAIT cycles pre-empts scanout; otherwise scanout wins while
// the display is active, and queued writes drain whenever scanout is idle or
// the beam is in blanking.
module vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bright,
    input  logic                          pix_req,
    input  logic [ADDR_W-1:0]             pix_addr,
    output logic                          pix_gnt,
    output logic                          pix_valid,
    output logic [DATA_W-1:0]             pix_data,
    input  logic                          cpu_wr_valid,
    output logic                          cpu_wr_ready,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // Owner of the VRAM port for the current cycle, in priority order.
    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_WR,
        SLOT_PIX_RD,
        SLOT_FORCE_WR
    } slot_t;

    // CPU write FIFO storage and bookkeeping. Pointers are PTR_W bits wide,
    // so with a power-of-two depth they wrap naturally.
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    // Starvation counter for the FIFO head.
    logic [WAIT_W-1:0] wait_cnt;

    // High in the cycle after a PIX_RD slot, while VRAM presents read data.
    logic              rd_pend;

    slot_t             slot;
    logic              fifo_empty;
    logic              wait_expired;
    logic              pix_req_eff;
    logic              push;
    logic              pop;

    assign fifo_empty   = (level == '0);
    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT));
    // During blanking scanout does not compete, so writes drain freely.
    assign pix_req_eff  = pix_req & bright;
    assign cpu_wr_ready = (level < LVL_W'(FIFO_DEPTH));
    assign push         = cpu_wr_valid & cpu_wr_ready;
    assign pop          = (slot == SLOT_FORCE_WR) || (slot == SLOT_WR);
    // Grant is suppressed while reset is held so no read appears accepted.
    assign pix_gnt      = (slot == SLOT_PIX_RD) && reset;
    assign fifo_level   = level;

    // Slot decision: forced write, then scanout read, then normal write.
    always_comb begin
        // NOTE: assign every always_comb output a default first so that no
        // path leaves it unassigned, which would infer a latch.
        slot = SLOT_IDLE;
        if (!fifo_empty && wait_expired) begin
            slot = SLOT_FORCE_WR;
        end else if (pix_req_eff) begin
            slot = SLOT_PIX_RD;
        end else if (!fifo_empty) begin
            slot = SLOT_WR;
        end
    end

    // FIFO storage: written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // level define which entries are meaningful, and leaving the array
        // out of reset lets it map onto plain RAM/flops without reset logic.
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Starvation counter: counts denied cycles, cleared by a write or empty FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (fifo_empty || pop) begin
            wait_cnt <= '0;
        end else if (!wait_expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered VRAM command for the slot chosen this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (slot)
                SLOT_FORCE_WR, SLOT_WR: begin
                    mem_addr  <= fifo_addr[rd_ptr];
                    mem_wdata <= fifo_data[rd_ptr];
                    mem_we    <= 1'b1;
                end
                SLOT_PIX_RD: begin
                    mem_addr <= pix_addr;
                    mem_we   <= 1'b0;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Read return path: capture VRAM data one edge after the address is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend   <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_pend   <= (slot == SLOT_PIX_RD);
            pix_valid <= rd_pend;
            if (rd_pend) begin
                pix_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural asynchronous-read VRAM.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        bright;
    logic        pix_req;
    logic [11:0] pix_addr;
    logic        pix_gnt;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .bright       (bright),
        .pix_req      (pix_req),
        .pix_addr     (pix_addr),
        .pix_gnt      (pix_gnt),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: background pattern addr[7:0]^0x3C, loaded while reset is low.
    logic [7:0] vram [4096];

    function automatic logic [7:0] vram_init(input logic [11:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) vram[i] <= vram_init(12'(i));
        end else if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = vram[mem_addr];

    task automatic test_reset();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h0AB;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== 21'h0) begin
            errors++; $display("FAIL reset_mem: got we=%0b addr=%h wdata=%h want all 0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({pix_valid, pix_data, fifo_level} !== 12'h0) begin
            errors++; $display("FAIL reset_pix_fifo: got valid=%0b data=%h level=%0d want all 0", pix_valid, pix_data, fifo_level);
        end
        checks++;
        if (pix_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_gnt: got %0b want 0", pix_gnt);
        end
        checks++;
        if (cpu_wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %0b want 1", cpu_wr_ready);
        end
        pix_req = 1'b0; bright = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, pix_valid} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got we=%0b valid=%0b want 0 0", mem_we, pix_valid);
        end
    endtask

    task automatic test_pix_read();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h010;
        #1;
        checks++;
        if (pix_gnt !== 1'b1) begin
            errors++; $display("FAIL read_gnt: got %0b want 1", pix_gnt);
        end
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, pix_valid} !== {12'h010, 1'b0, 1'b0}) begin
            errors++; $display("FAIL read_addr: got addr=%h we=%0b valid=%0b want 010 0 0", mem_addr, mem_we, pix_valid);
        end
        pix_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 8'h2C}) begin
            errors++; $display("FAIL read_data: got valid=%0b data=%h want 1 2c", pix_valid, pix_data);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++; $display("FAIL read_pulse: got valid=%0b want 0", pix_valid);
        end
    endtask

    task automatic test_blank_drain();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h0F0;
        for (int i = 0; i < 4; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 12'(12'h100 + i);
            cpu_wr_data  = 8'(8'hA0 + i);
            @(negedge clk);
        end
        checks++;
        if ({fifo_level, cpu_wr_ready} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL fill_full: got level=%0d ready=%0b want 4 0", fifo_level, cpu_wr_ready);
        end
        cpu_wr_valid = 1'b0; bright = 1'b0;
        #1;
        checks++;
        if (pix_gnt !== 1'b0) begin
            errors++; $display("FAIL blank_gnt: got %0b want 0", pix_gnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_addr, mem_wdata, fifo_level} !==
                {1'b1, 12'(12'h100 + i), 8'(8'hA0 + i), 3'(3 - i)}) begin
                errors++; $display("FAIL drain_%0d: got we=%0b addr=%h data=%h level=%0d want 1 %h %h %0d",
                                   i, mem_we, mem_addr, mem_wdata, fifo_level, 12'(12'h100 + i), 8'(8'hA0 + i), 3 - i);
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_we, fifo_level} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL drain_done: got we=%0b level=%0d want 0 0", mem_we, fifo_level);
        end
        pix_req = 1'b0;
    endtask

    task automatic test_force_write();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h030;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h200; cpu_wr_data = 8'h77;
        @(negedge clk);
        cpu_wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({pix_gnt, mem_we} !== 2'b10) begin
                errors++; $display("FAIL denied_%0d: got gnt=%0b we=%0b want 1 0", i, pix_gnt, mem_we);
            end
            @(negedge clk);
        end
        checks++;
        if ({pix_gnt, fifo_level} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL force_slot: got gnt=%0b level=%0d want 0 1", pix_gnt, fifo_level);
        end
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, fifo_level} !== {1'b1, 12'h200, 8'h77, 3'd0}) begin
            errors++; $display("FAIL force_issue: got we=%0b addr=%h data=%h level=%0d want 1 200 77 0",
                               mem_we, mem_addr, mem_wdata, fifo_level);
        end
        checks++;
        if (pix_gnt !== 1'b1) begin
            errors++; $display("FAIL gnt_resume: got %0b want 1", pix_gnt);
        end
        pix_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic got_ready;
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h040;
        for (int i = 0; i < 4; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 12'(12'h300 + i);
            cpu_wr_data  = 8'(8'hB0 + i);
            @(negedge clk);
        end
        checks++;
        if ({fifo_level, cpu_wr_ready} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL wrap_full: got level=%0d ready=%0b want 4 0", fifo_level, cpu_wr_ready);
        end
        cpu_wr_addr = 12'h304; cpu_wr_data = 8'hB4;
        got_ready = 1'b0;
        for (int k = 0; k < 20 && !got_ready; k++) begin
            @(negedge clk);
            if (cpu_wr_ready) got_ready = 1'b1;
        end
        checks++;
        if (got_ready !== 1'b1) begin
            errors++; $display("FAIL wrap_ready_timeout: got ready=%0b want 1 within 20 cycles", cpu_wr_ready);
        end
        checks++;
        if ({fifo_level, mem_we, mem_addr, mem_wdata} !== {3'd3, 1'b1, 12'h300, 8'hB0}) begin
            errors++; $display("FAIL wrap_forced: got level=%0d we=%0b addr=%h data=%h want 3 1 300 b0",
                               fifo_level, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++; $display("FAIL wrap_refill: got level=%0d want 4", fifo_level);
        end
        cpu_wr_addr = 12'h305; cpu_wr_data = 8'hB5; bright = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_level, mem_we, mem_addr} !== {3'd3, 1'b1, 12'h301}) begin
            errors++; $display("FAIL wrap_pop1: got level=%0d we=%0b addr=%h want 3 1 301", fifo_level, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({fifo_level, mem_we, mem_addr, mem_wdata} !== {3'd3, 1'b1, 12'h302, 8'hB2}) begin
            errors++; $display("FAIL push_pop_same_edge: got level=%0d we=%0b addr=%h data=%h want 3 1 302 b2",
                               fifo_level, mem_we, mem_addr, mem_wdata);
        end
        cpu_wr_valid = 1'b0;
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'(12'h300 + i), 8'(8'hB0 + i)}) begin
                errors++; $display("FAIL wrap_order_%0d: got we=%0b addr=%h data=%h want 1 %h %h",
                                   i, mem_we, mem_addr, mem_wdata, 12'(12'h300 + i), 8'(8'hB0 + i));
            end
        end
        @(negedge clk);
        checks++;
        if ({fifo_level, mem_we} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL wrap_done: got level=%0d we=%0b want 0 0", fifo_level, mem_we);
        end
        pix_req = 1'b0;
    endtask

    task automatic test_no_forward();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h020;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h020; cpu_wr_data = 8'h55;
        #1;
        checks++;
        if (pix_gnt !== 1'b1) begin
            errors++; $display("FAIL nofwd_gnt: got %0b want 1", pix_gnt);
        end
        @(negedge clk);
        cpu_wr_valid = 1'b0; pix_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 8'h1C}) begin
            errors++; $display("FAIL nofwd_old: got valid=%0b data=%h want 1 1c", pix_valid, pix_data);
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h020, 8'h55}) begin
            errors++; $display("FAIL nofwd_write: got we=%0b addr=%h data=%h want 1 020 55", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        pix_req = 1'b1;
        @(negedge clk);
        pix_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 8'h55}) begin
            errors++; $display("FAIL nofwd_new: got valid=%0b data=%h want 1 55", pix_valid, pix_data);
        end
    endtask

    task automatic test_back_to_back();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h050;
        @(negedge clk);
        pix_addr = 12'h051;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 8'h6C}) begin
            errors++; $display("FAIL b2b_0: got valid=%0b data=%h want 1 6c", pix_valid, pix_data);
        end
        pix_addr = 12'h052;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 8'h6D}) begin
            errors++; $display("FAIL b2b_1: got valid=%0b data=%h want 1 6d", pix_valid, pix_data);
        end
        pix_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_data} !== {1'b1, 8'h6E}) begin
            errors++; $display("FAIL b2b_2: got valid=%0b data=%h want 1 6e", pix_valid, pix_data);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got valid=%0b want 0", pix_valid);
        end
    endtask

    task automatic test_reset_midop();
        bright = 1'b1; pix_req = 1'b1; pix_addr = 12'h060;
        for (int i = 0; i < 3; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 12'(12'h400 + i);
            cpu_wr_data  = 8'(8'hC0 + i);
            @(negedge clk);
        end
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++; $display("FAIL midop_queued: got level=%0d want 3", fifo_level);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, pix_valid, pix_data, fifo_level, pix_gnt} !== 34'h0) begin
            errors++; $display("FAIL midop_clear: got we=%0b addr=%h wdata=%h valid=%0b data=%h level=%0d gnt=%0b want all 0",
                               mem_we, mem_addr, mem_wdata, pix_valid, pix_data, fifo_level, pix_gnt);
        end
        pix_req = 1'b0; cpu_wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, pix_valid} !== 2'b00) begin
                errors++; $display("FAIL midop_quiet_%0d: got we=%0b valid=%0b want 0 0", i, mem_we, pix_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b0; bright = 1'b0; pix_req = 1'b0; pix_addr = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        test_reset();
        test_pix_read();
        test_blank_drain();
        test_force_write();
        test_wrap();
        test_no_forward();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
